cs_sense_ctrl: RTL
==================

CS_SENSE_CTRL -- requirements
Module: cs_sense_ctrl

Interface
REQ-001 The block SHALL have parameter DEFAULT_THRESHOLD, default 32'd4096, meaning the threshold value driven after reset.
REQ-002 The block SHALL have parameter DP_LAT, default 4, meaning the cycles from last windowed sample to a valid present_next.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have the port run, input, 1 bit: receive chain enabled; sensing proceeds only while high.
REQ-006 The block SHALL have the port strobe, input, 1 bit: one valid I/Q sample this cycle.
REQ-007 The block SHALL have the port window_len, input, 16 bits: samples per sensing window; 0 is treated as 1.
REQ-008 The block SHALL have the port busy_hold, input, 4 bits: consecutive present windows needed to declare busy; 0 is treated as 1.
REQ-009 The block SHALL have the port idle_hold, input, 4 bits: consecutive absent windows needed to declare idle; 0 is treated as 1.
REQ-010 The block SHALL have the port threshold_in, input, 32 bits: new threshold value.
REQ-011 The block SHALL have the port threshold_wr, input, 1 bit: one-cycle write of threshold_in.
REQ-012 The block SHALL have the port present_next, input, 1 bit: datapath decision (energy above threshold).
REQ-013 The block SHALL have the port dp_rst, output, 1 bit: datapath accumulator clear (datapath rst_dev).
REQ-014 The block SHALL have the port dp_wr_en, output, 1 bit: datapath sample write enable.
REQ-015 The block SHALL have the port threshold_out, output, 32 bits: active threshold to the datapath.
REQ-016 The block SHALL have the port threshold_changed, output, 1 bit: one-cycle pulse when threshold_out updates.
REQ-017 The block SHALL have the port channel_busy, output, 1 bit: hysteresis-filtered occupancy.
REQ-018 The block SHALL have the port window_count, output, 32 bits: completed windows, wraps from 2^32-1 to 0.
REQ-019 The block SHALL have the port busy_count, output, 32 bits: completed windows with present_next=1, wraps.

Function
REQ-020 The FSM SHALL have the states IDLE, CLEAR, SENSE and EVAL, each encoded one-hot.
REQ-021 In IDLE, the FSM SHALL go to CLEAR on the first cycle run=1.
REQ-022 CLEAR SHALL last exactly 1 cycle with dp_rst=1, zero the sample counter, apply any pending threshold, then go to SENSE.
REQ-023 In SENSE, dp_wr_en SHALL equal strobe, and each strobe SHALL increment the sample counter.
REQ-024 The strobe that brings the sample count to max(window_len,1) SHALL be the last sample written, and the FSM SHALL enter EVAL on the next cycle.
REQ-025 window_len SHALL be sampled in CLEAR, and changes during SENSE SHALL not affect the current window.
REQ-026 EVAL SHALL wait DP_LAT cycles with dp_wr_en=0, then sample present_next on its final cycle.
REQ-027 On that final EVAL cycle, the block SHALL increment window_count, increment busy_count if present_next=1, and update the hysteresis.
REQ-028 After EVAL, the FSM SHALL go to CLEAR if run=1, else to IDLE.
REQ-029 If run falls in CLEAR, SENSE or EVAL, the FSM SHALL go to IDLE next cycle; the window is discarded, no counter or hysteresis update occurs, and channel_busy is held.
REQ-030 threshold_wr SHALL load threshold_in into a pending register and set a pending flag, with the last write winning.
REQ-031 A pending threshold SHALL be applied only in CLEAR: threshold_out takes the pending value on the CLEAR-exit edge, threshold_changed pulses 1 cycle, and the pending flag clears.
REQ-032 A threshold_wr in the same cycle as CLEAR SHALL remain pending for the next window.
REQ-033 The hysteresis SHALL keep separate 4-bit present-run and absent-run counters that saturate at 15; a window result resets the opposite counter.
REQ-034 channel_busy SHALL set when the present-run counter reaches max(busy_hold,1) and clear when the absent-run counter reaches max(idle_hold,1).
REQ-035 dp_rst, dp_wr_en and threshold_changed SHALL be registered outputs with no combinational path from inputs, except dp_wr_en, which equals strobe gated by the SENSE state register.

Reset
REQ-036 While rst=1, the block SHALL force the state to IDLE, dp_rst=1, dp_wr_en=0, threshold_out=DEFAULT_THRESHOLD, threshold_changed=0, channel_busy=0, window_count=0, busy_count=0, and all internal counters and the pending flag to 0.
REQ-037 When rst rises mid-window, the block SHALL abandon the window immediately with no count update.
REQ-038 After rst falls, dp_rst SHALL be 0 from the first clock edge in IDLE.

Verification
REQ-039 The bench SHALL check: window_len=4, DP_LAT=4, run=1, strobe every cycle -> dp_rst 1 cycle, dp_wr_en 4 cycles, window_count=1 exactly 5 cycles after last strobe.
REQ-040 The bench SHALL check: window_len=0, strobe every third cycle -> each window writes exactly 1 sample.
REQ-041 The bench SHALL check: busy_hold=3, idle_hold=2, present_next pattern 1,1,0,1,1,1,0,0 -> channel_busy rises after the 6th window and falls after the 8th; busy_count=5.
REQ-042 The bench SHALL check: threshold_wr 0x100 then 0x200 during SENSE -> threshold_out=0x200 with a single threshold_changed pulse at the next CLEAR; a write coincident with CLEAR applies one window later.
REQ-043 The bench SHALL check: run dropped after 2 of 8 samples -> FSM in IDLE, window_count unchanged, and the next run starts with dp_rst.
REQ-044 The bench SHALL check: rst asserted asynchronously mid-SENSE -> all outputs at reset values before the next edge, and threshold_out=4096.

Source files
------------

// File: rtl/cs_sense_ctrl.sv
// rtl/cs_sense_ctrl.sv - spectrum-sensing window controller with threshold staging and hysteresis
module cs_sense_ctrl #(
    parameter logic [31:0] DEFAULT_THRESHOLD = 32'd4096,
    parameter int          DP_LAT            = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        strobe,
    input  logic [15:0] window_len,
    input  logic [3:0]  busy_hold,
    input  logic [3:0]  idle_hold,
    input  logic [31:0] threshold_in,
    input  logic        threshold_wr,
    input  logic        present_next,
    output logic        dp_rst,
    output logic        dp_wr_en,
    output logic [31:0] threshold_out,
    output logic        threshold_changed,
    output logic        channel_busy,
    output logic [31:0] window_count,
    output logic [31:0] busy_count
);

    // One-hot states; bit positions double as state-register taps.
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_CLEAR = 4'b0010;
    localparam logic [3:0] ST_SENSE = 4'b0100;
    localparam logic [3:0] ST_EVAL  = 4'b1000;
    localparam int         SENSE_BIT = 2;

    // A datapath latency below one cycle still needs one EVAL cycle to sample.
    localparam int          EVAL_CYC  = (DP_LAT < 1) ? 1 : DP_LAT;
    localparam logic [15:0] EVAL_LAST = 16'(EVAL_CYC - 1);

    logic [3:0]  state_q, state_d;
    logic [15:0] smp_cnt_q, smp_cnt_d;
    logic [15:0] win_len_q, win_len_d;
    logic [15:0] eval_cnt_q, eval_cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_val_q, pend_val_d;
    logic [31:0] thr_q, thr_d;
    logic        thr_chg_q, thr_chg_d;
    logic        dp_rst_q, dp_rst_d;
    logic        busy_q, busy_d;
    logic [31:0] wc_q, wc_d;
    logic [31:0] bc_q, bc_d;
    logic [3:0]  prun_q, prun_d;
    logic [3:0]  arun_q, arun_d;
    logic [3:0]  busy_hold_eff, idle_hold_eff;

    assign busy_hold_eff = (busy_hold == 4'd0) ? 4'd1 : busy_hold;
    assign idle_hold_eff = (idle_hold == 4'd0) ? 4'd1 : idle_hold;

    // Next-state: window sequencing, threshold staging, window evaluation.
    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        win_len_d  = win_len_q;
        eval_cnt_d = eval_cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        thr_d      = thr_q;
        thr_chg_d  = 1'b0;
        busy_d     = busy_q;
        wc_d       = wc_q;
        bc_d       = bc_q;
        prun_d     = prun_q;
        arun_d     = arun_q;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                smp_cnt_d  = 16'd0;
                eval_cnt_d = 16'd0;
                win_len_d  = (window_len == 16'd0) ? 16'd1 : window_len;
                state_d    = run ? ST_SENSE : ST_IDLE;
            end
            ST_SENSE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (strobe) begin
                    smp_cnt_d = smp_cnt_q + 16'd1;
                    if (smp_cnt_d == win_len_q) state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (eval_cnt_q == EVAL_LAST) begin
                    state_d = ST_CLEAR;
                    wc_d    = wc_q + 32'd1;
                    if (present_next) begin
                        bc_d   = bc_q + 32'd1;
                        prun_d = (prun_q == 4'd15) ? 4'd15 : prun_q + 4'd1;
                        arun_d = 4'd0;
                        if (prun_d >= busy_hold_eff) busy_d = 1'b1;
                    end else begin
                        arun_d = (arun_q == 4'd15) ? 4'd15 : arun_q + 4'd1;
                        prun_d = 4'd0;
                        if (arun_d >= idle_hold_eff) busy_d = 1'b0;
                    end
                end else begin
                    eval_cnt_d = eval_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pending threshold moves to the datapath only between windows.
        if (state_q == ST_CLEAR && pend_q) begin
            thr_d     = pend_val_q;
            thr_chg_d = 1'b1;
            pend_d    = 1'b0;
        end
        // A write coincident with CLEAR overrides the clear and stays pending.
        if (threshold_wr) begin
            pend_val_d = threshold_in;
            pend_d     = 1'b1;
        end
    end

    assign dp_rst_d = (state_d == ST_CLEAR);

    // State and output registers; reset holds the datapath in clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            smp_cnt_q  <= 16'd0;
            win_len_q  <= 16'd0;
            eval_cnt_q <= 16'd0;
            pend_q     <= 1'b0;
            pend_val_q <= 32'd0;
            thr_q      <= DEFAULT_THRESHOLD;
            thr_chg_q  <= 1'b0;
            dp_rst_q   <= 1'b1;
            busy_q     <= 1'b0;
            wc_q       <= 32'd0;
            bc_q       <= 32'd0;
            prun_q     <= 4'd0;
            arun_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            win_len_q  <= win_len_d;
            eval_cnt_q <= eval_cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            thr_q      <= thr_d;
            thr_chg_q  <= thr_chg_d;
            dp_rst_q   <= dp_rst_d;
            busy_q     <= busy_d;
            wc_q       <= wc_d;
            bc_q       <= bc_d;
            prun_q     <= prun_d;
            arun_q     <= arun_d;
        end
    end

    assign dp_wr_en          = strobe & state_q[SENSE_BIT];
    assign dp_rst            = dp_rst_q;
    assign threshold_out     = thr_q;
    assign threshold_changed = thr_chg_q;
    assign channel_busy      = busy_q;
    assign window_count      = wc_q;
    assign busy_count        = bc_q;

endmodule
